// File: rtl/spiral_pkg.sv
// Shared types and default widths for the spiral re-orderer.
package spiral_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_R_WIDTH    = 3;
    localparam int DEF_C_WIDTH    = 3;

    // The block either fills its buffer or drains it, never both at once.
    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Current heading of the spiral walk; turns are always clockwise.
    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        UP    = 2'd3
    } dir_t;

endpackage

// File: rtl/spiral_addr_gen.sv
// Spiral read-address generator: walks a row x col window clockwise,
// shrinking the bounds after each edge, and flags the final word.
module spiral_addr_gen
    import spiral_pkg::*;
#(
    parameter int R_WIDTH = DEF_R_WIDTH,
    parameter int C_WIDTH = DEF_C_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               init,
    input  logic               step,
    input  logic [R_WIDTH-1:0] row,
    input  logic [C_WIDTH-1:0] col,
    output logic [R_WIDTH-1:0] r,
    output logic [C_WIDTH-1:0] c,
    output logic               last
);

    localparam int CNT_W = R_WIDTH + C_WIDTH;

    logic [R_WIDTH-1:0] r_q, r_d, top_q, top_d, bottom_q, bottom_d;
    logic [C_WIDTH-1:0] c_q, c_d, left_q, left_d, right_q, right_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, total_q, total_d;
    dir_t               dir_q, dir_d;

    // Next pointer/bound computation: init loads the full window, step
    // advances one word; moves past bounds on the last word are harmless
    // because the next init overwrites everything.
    always_comb begin
        r_d      = r_q;
        c_d      = c_q;
        top_d    = top_q;
        bottom_d = bottom_q;
        left_d   = left_q;
        right_d  = right_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        if (init) begin
            r_d      = '0;
            c_d      = '0;
            top_d    = '0;
            bottom_d = row - R_WIDTH'(1);
            left_d   = '0;
            right_d  = col - C_WIDTH'(1);
            dir_d    = RIGHT;
            cnt_d    = '0;
            total_d  = CNT_W'(row) * CNT_W'(col);
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            unique case (dir_q)
                RIGHT: begin
                    if (c_q < right_q) begin
                        c_d = c_q + C_WIDTH'(1);
                    end else begin
                        top_d = top_q + R_WIDTH'(1);
                        dir_d = DOWN;
                        r_d   = r_q + R_WIDTH'(1);
                    end
                end
                DOWN: begin
                    if (r_q < bottom_q) begin
                        r_d = r_q + R_WIDTH'(1);
                    end else begin
                        right_d = right_q - C_WIDTH'(1);
                        dir_d   = LEFT;
                        c_d     = c_q - C_WIDTH'(1);
                    end
                end
                LEFT: begin
                    if (c_q > left_q) begin
                        c_d = c_q - C_WIDTH'(1);
                    end else begin
                        bottom_d = bottom_q - R_WIDTH'(1);
                        dir_d    = UP;
                        r_d      = r_q - R_WIDTH'(1);
                    end
                end
                UP: begin
                    if (r_q > top_q) begin
                        r_d = r_q - R_WIDTH'(1);
                    end else begin
                        left_d = left_q + C_WIDTH'(1);
                        dir_d  = RIGHT;
                        c_d    = c_q + C_WIDTH'(1);
                    end
                end
                default: dir_d = RIGHT;
            endcase
        end
    end

    // Pointer, bound and counter registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_q      <= '0;
            c_q      <= '0;
            top_q    <= '0;
            bottom_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            dir_q    <= RIGHT;
            cnt_q    <= '0;
            total_q  <= '0;
        end else begin
            r_q      <= r_d;
            c_q      <= c_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            left_q   <= left_d;
            right_q  <= right_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
        end
    end

    assign r    = r_q;
    assign c    = c_q;
    assign last = ((cnt_q + CNT_W'(1)) == total_q);

endmodule

// File: rtl/spiral_reorder.sv
// Streaming matrix re-orderer: loads one frame in raster order, then
// emits it in clockwise spiral order. rstn is an active-high reset.
module spiral_reorder
    import spiral_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int R_WIDTH    = DEF_R_WIDTH,
    parameter int C_WIDTH    = DEF_C_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [R_WIDTH-1:0]    row,
    input  logic [C_WIDTH-1:0]    col,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_rdy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_rdy
);

    localparam int ADDR_W = R_WIDTH + C_WIDTH;
    localparam int DEPTH  = 1 << ADDR_W;

    state_t               state_q, state_d;
    logic [R_WIDTH-1:0]   r_in_q, r_in_d, row_q, row_d;
    logic [C_WIDTH-1:0]   c_in_q, c_in_d, col_q, col_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic               frame_start, shape_ok, in_xfer, wr_en, in_last, out_xfer;
    logic [R_WIDTH-1:0] eff_row, rd_r;
    logic [C_WIDTH-1:0] eff_col, rd_c;
    logic               rd_last;

    // Handshake outputs; both stay low while reset is held.
    assign data_in_rdy    = !rstn && (state_q == LOAD);
    assign data_out_valid = !rstn && (state_q == DRAIN);
    assign data_out       = data_out_valid ? mem_q[{rd_r, rd_c}] : '0;

    // The shape is sampled live on the first beat and from the captured
    // copy afterwards, so a frame is self-consistent even if row/col move.
    assign frame_start = (r_in_q == '0) && (c_in_q == '0);
    assign eff_row     = frame_start ? row : row_q;
    assign eff_col     = frame_start ? col : col_q;
    assign shape_ok    = (eff_row != '0) && (eff_col != '0);
    assign in_xfer     = data_in_valid && data_in_rdy;
    assign wr_en       = in_xfer && shape_ok;
    assign in_last     = wr_en && (r_in_q == eff_row - R_WIDTH'(1))
                               && (c_in_q == eff_col - C_WIDTH'(1));
    assign out_xfer    = data_out_valid && data_out_rdy;

    // Raster write counter, shape capture and LOAD/DRAIN sequencing.
    always_comb begin
        state_d = state_q;
        r_in_d  = r_in_q;
        c_in_d  = c_in_q;
        row_d   = row_q;
        col_d   = col_q;
        if (wr_en) begin
            if (frame_start) begin
                row_d = row;
                col_d = col;
            end
            if (c_in_q == eff_col - C_WIDTH'(1)) begin
                c_in_d = '0;
                r_in_d = r_in_q + R_WIDTH'(1);
            end else begin
                c_in_d = c_in_q + C_WIDTH'(1);
            end
            if (in_last) begin
                state_d = DRAIN;
                r_in_d  = '0;
                c_in_d  = '0;
            end
        end
        if (out_xfer && rd_last) begin
            state_d = LOAD;
        end
    end

    // Buffer write: only the addressed word changes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (wr_en) begin
            mem_d[{r_in_q, c_in_q}] = data_in;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= LOAD;
            r_in_q  <= '0;
            c_in_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            r_in_q  <= r_in_d;
            c_in_q  <= c_in_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Frame buffer; contents after reset are don't-care, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    spiral_addr_gen #(
        .R_WIDTH(R_WIDTH),
        .C_WIDTH(C_WIDTH)
    ) u_addr_gen (
        .clk (clk),
        .rstn(rstn),
        .init(in_last),
        .step(out_xfer),
        .row (eff_row),
        .col (eff_col),
        .r   (rd_r),
        .c   (rd_c),
        .last(rd_last)
    );

endmodule

// File: tb/tb_spiral_reorder.sv
// Self-checking bench for spiral_reorder: directed frame shapes plus
// randomized data, input gaps and output back-pressure.
module tb_spiral_reorder;

    localparam int DW = 8;
    localparam int RW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          data_in_rdy;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_rdy;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] frame [64];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    spiral_reorder #(
        .DATA_WIDTH(DW),
        .R_WIDTH   (RW),
        .C_WIDTH   (CW)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .row           (row),
        .col           (col),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_rdy   (data_in_rdy),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_rdy  (data_out_rdy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: walk the grid, turning clockwise whenever the next cell
    // is off the grid or already visited.
    function automatic void build_expected(input int nr, input int nc);
        bit seen [8][8];
        int dr [4] = '{0, 1, 0, -1};
        int dc [4] = '{1, 0, -1, 0};
        int r = 0, c = 0, d = 0, nr2, nc2;
        exp_q.delete();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) seen[i][j] = 1'b0;
        for (int k = 0; k < nr * nc; k++) begin
            exp_q.push_back(frame[r * nc + c]);
            seen[r][c] = 1'b1;
            nr2 = r + dr[d];
            nc2 = c + dc[d];
            if (nr2 < 0 || nr2 >= nr || nc2 < 0 || nc2 >= nc || seen[nr2][nc2]) begin
                d   = (d + 1) % 4;
                nr2 = r + dr[d];
                nc2 = c + dc[d];
            end
            r = nr2;
            c = nc2;
        end
    endfunction

    task automatic fill_frame(input int n, input bit rnd);
        for (int i = 0; i < 64; i++) frame[i] = rnd ? DW'($urandom) : DW'(i);
        if (n > 64) $fatal(1, "FAIL fill_frame: frame too large");
    endtask

    // Feed one frame; row/col are scrambled after the first beat to make
    // sure the block relies on its captured copy.
    task automatic load_frame(input int nr, input int nc, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < nr * nc) begin
            if (cyc > 2000) begin
                tests++;
                fails++;
                $display("FAIL load_timeout: observed %0d beats expected %0d", idx, nr * nc);
                data_in_valid = 1'b0;
                return;
            end
            chk("in_rdy_load", data_in_rdy, 1);
            chk("out_valid_load", data_out_valid, 0);
            row           = (idx == 0) ? RW'(nr) : RW'($urandom);
            col           = (idx == 0) ? CW'(nc) : CW'($urandom);
            data_in_valid = ($urandom_range(99) >= gap_pct);
            data_in       = frame[idx];
            acc           = data_in_valid && data_in_rdy;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        data_in_valid = 1'b0;
        chk("first_valid_latency", data_out_valid, 1);
    endtask

    task automatic drain_frame(input int nr, input int nc, input int rdy_pct);
        int k = 0;
        int cyc = 0;
        bit stall = 1'b0;
        logic [DW-1:0] prev = '0;
        build_expected(nr, nc);
        while (k < nr * nc) begin
            if (cyc > 2000) begin
                tests++;
                fails++;
                $display("FAIL drain_timeout: observed %0d words expected %0d", k, nr * nc);
                data_out_rdy = 1'b0;
                return;
            end
            chk("in_rdy_drain", data_in_rdy, 0);
            chk("out_valid_drain", data_out_valid, 1);
            if (stall) chk("stall_hold", data_out, prev);
            data_out_rdy = ($urandom_range(99) < rdy_pct);
            if (data_out_rdy) begin
                chk($sformatf("out_%0dx%0d[%0d]", nr, nc, k), data_out, exp_q[k]);
                k++;
            end
            stall = !data_out_rdy;
            prev  = data_out;
            @(posedge clk);
            #1;
            cyc++;
        end
        data_out_rdy = 1'b0;
        chk("done_valid", data_out_valid, 0);
        chk("done_in_rdy", data_in_rdy, 1);
        $display("[TB] frame %0dx%0d drained in %0d cycles", nr, nc, cyc);
    endtask

    task automatic run_frame(input int nr, input int nc, input int gap_pct,
                             input int rdy_pct, input bit rnd);
        fill_frame(nr * nc, rnd);
        load_frame(nr, nc, gap_pct);
        drain_frame(nr, nc, rdy_pct);
    endtask

    initial begin
        rstn          = 1'b1;
        row           = '0;
        col           = '0;
        data_in       = '0;
        data_in_valid = 1'b0;
        data_out_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_rdy", data_in_rdy, 0);
        chk("rst_out_valid", data_out_valid, 0);
        chk("rst_data_out", data_out, 0);
        rstn = 1'b0;
        #1;
        chk("post_rst_in_rdy", data_in_rdy, 1);

        // Directed shapes.
        run_frame(4, 4, 0, 100, 1'b0);
        run_frame(3, 4, 0, 100, 1'b0);
        run_frame(1, 5, 0, 100, 1'b0);
        run_frame(4, 1, 0, 100, 1'b0);
        fill_frame(1, 1'b0);
        frame[0] = 8'hA5;
        load_frame(1, 1, 0);
        drain_frame(1, 1, 100);
        run_frame(3, 3, 0, 50, 1'b0);
        run_frame(7, 7, 30, 100, 1'b0);
        run_frame(2, 3, 0, 100, 1'b0);

        // A beat offered with a zero-row shape must be dropped.
        row           = '0;
        col           = 3'd3;
        data_in       = 8'hEE;
        data_in_valid = 1'b1;
        @(posedge clk);
        #1;
        data_in_valid = 1'b0;
        chk("zero_shape_no_drain", data_out_valid, 0);
        chk("zero_shape_in_rdy", data_in_rdy, 1);
        run_frame(2, 2, 0, 100, 1'b0);

        // Reset in the middle of a drain.
        fill_frame(9, 1'b0);
        load_frame(3, 3, 0);
        data_out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        data_out_rdy = 1'b0;
        rstn         = 1'b1;
        #1;
        chk("mid_rst_in_rdy", data_in_rdy, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_valid", data_out_valid, 0);
        chk("mid_rst_data", data_out, 0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_release_in_rdy", data_in_rdy, 1);
        run_frame(2, 2, 0, 100, 1'b0);

        // Random shapes, data, gaps and back-pressure.
        for (int t = 0; t < 8; t++) begin
            run_frame($urandom_range(7, 1), $urandom_range(7, 1), 25, 60, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
